// File: rtl/skid_pipeline.sv
// skid_pipeline
//   Chain of STAGES skid-buffered valid/ready register stages. Every forward
//   (valid/data) and backward (ready) path is registered, so the block cuts
//   timing in both directions while sustaining one transfer per cycle.
//   Each stage holds a main slot and a skid slot, giving 2*STAGES words of
//   elasticity in total.
//
// Parameters
//   DATA_WIDTH : payload width in bits (>=1)
//   STAGES     : number of skid stages (>=1)
//   CNT_W      : occupancy width, derived from STAGES
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, clears all stored words
//   flush     : synchronous discard of all stored words
//   in_data   : upstream payload
//   in_valid  : upstream word offered
//   in_ready  : stage 0 can accept (registered state, no path from out_ready)
//   out_data  : last-stage main register payload
//   out_valid : last-stage main register holds a word
//   out_ready : downstream accepts
//   occupancy : number of words held across all stages
module skid_pipeline #(
  parameter  int DATA_WIDTH = 32,
  parameter  int STAGES     = 2,
  localparam int CNT_W      = $clog2(2*STAGES+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      occupancy
);

  // Per-stage state gathered into vectors so neighbouring stages and the
  // occupancy counter can reach it.
  logic [STAGES-1:0]     main_vld;
  logic [STAGES-1:0]     skid_vld;
  logic [DATA_WIDTH-1:0] main_dat [STAGES];

  // Depends only on stage-0 skid state plus the local flush/reset controls.
  assign in_ready = !skid_vld[0] && !flush && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  main_v;
    logic                  skid_v;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  off_v;
    logic [DATA_WIDTH-1:0] off_d;
    logic                  dn_rdy;
    logic                  acc;
    logic                  drn;

    if (k == 0) begin : g_head
      assign off_v = in_valid && in_ready;
      assign off_d = in_data;
    end else begin : g_body
      assign off_v = main_vld[k-1];
      assign off_d = main_dat[k-1];
    end

    // Downstream ready is the next stage's registered skid-empty flag,
    // which is what keeps the backward path one register per stage.
    if (k == STAGES-1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_link
      assign dn_rdy = !skid_vld[k+1];
    end

    assign acc = off_v && !skid_v;
    assign drn = main_v && dn_rdy;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (drn) begin
        // With a full skid, acc is impossible and main refills from skid;
        // otherwise main refills only if a new word arrives.
        main_v <= skid_v || acc;
        skid_v <= 1'b0;
      end else if (acc) begin
        if (main_v) begin
          skid_v <= 1'b1;
        end else begin
          main_v <= 1'b1;
        end
      end
    end

    // Payload registers carry no reset; the valid flags qualify them.
    always_ff @(posedge clk) begin
      if (drn && skid_v) begin
        main_d <= skid_d;
      end else if (acc && (drn || !main_v)) begin
        main_d <= off_d;
      end else if (acc) begin
        skid_d <= off_d;
      end
    end

    assign main_vld[k] = main_v;
    assign skid_vld[k] = skid_v;
    assign main_dat[k] = main_d;
  end

  assign out_valid = main_vld[STAGES-1];
  assign out_data  = main_dat[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occupancy = occupancy + CNT_W'(main_vld[i]) + CNT_W'(skid_vld[i]);
    end
  end

endmodule

// File: tb/tb_skid_pipeline.sv
module tb_skid_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;

  // Index 0: STAGES=1, index 1: STAGES=2, index 2: STAGES=4.
  logic        ir_a  [3];
  logic        ov_a  [3];
  logic [31:0] od_a  [3];
  logic [3:0]  occ_a [3];
  logic [1:0]  occ_s1;
  logic [2:0]  occ_s2;
  logic [3:0]  occ_s4;

  skid_pipeline #(.DATA_WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_a[0]), .out_data(od_a[0]), .out_valid(ov_a[0]),
    .out_ready(out_ready), .occupancy(occ_s1));

  skid_pipeline #(.DATA_WIDTH(32), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_a[1]), .out_data(od_a[1]), .out_valid(ov_a[1]),
    .out_ready(out_ready), .occupancy(occ_s2));

  skid_pipeline #(.DATA_WIDTH(32), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_a[2]), .out_data(od_a[2]), .out_valid(ov_a[2]),
    .out_ready(out_ready), .occupancy(occ_s4));

  assign occ_a[0] = {2'b00, occ_s1};
  assign occ_a[1] = {1'b0, occ_s2};
  assign occ_a[2] = occ_s4;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t tbl [16];

  function automatic int stages_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic vec_t mk(input int r, input int f, input int v, input int id,
                              input int o, input int eir, input int eov,
                              input int eod, input int eocc);
    vec_t x;
    x.rst   = (r != 0);
    x.flush = (f != 0);
    x.iv    = (v != 0);
    x.id    = 32'(id);
    x.ordy  = (o != 0);
    x.e_ir  = (eir != 0);
    x.e_ov  = (eov != 0);
    x.e_od  = 32'(eod);
    x.e_occ = 4'(eocc);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later,
  // well before the next rising edge.
  task automatic drive(input int r, input int f, input int v, input logic [31:0] d,
                       input int o);
    @(negedge clk);
    rst       = (r != 0);
    flush     = (f != 0);
    in_valid  = (v != 0);
    in_data   = d;
    out_ready = (o != 0);
    #2;
  endtask

  logic [31:0] q [$];
  logic [31:0] exp_word;
  logic        ir_snap;
  logic        seen;
  int          s;
  int          sent;
  int          got;
  int          cyc;
  int          v_i;
  int          o_i;
  logic [31:0] d_i;
  int          acc_n;
  int          del_n;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    drive(1, 0, 0, 32'h0, 0);

    // ---- Table: reset hold, backpressure fill on STAGES=2, then release ----
    tbl[0]  = mk(1, 0, 1, 'hEE, 0, 0, 0, 'h00, 0);
    tbl[1]  = mk(1, 0, 1, 'hEE, 0, 0, 0, 'h00, 0);
    tbl[2]  = mk(1, 0, 1, 'hEE, 0, 0, 0, 'h00, 0);
    tbl[3]  = mk(0, 0, 1, 'hA0, 0, 1, 0, 'h00, 0);
    tbl[4]  = mk(0, 0, 1, 'hA1, 0, 1, 0, 'h00, 1);
    tbl[5]  = mk(0, 0, 1, 'hA2, 0, 1, 1, 'hA0, 2);
    tbl[6]  = mk(0, 0, 1, 'hA3, 0, 1, 1, 'hA0, 3);
    tbl[7]  = mk(0, 0, 1, 'hA4, 0, 0, 1, 'hA0, 4);
    tbl[8]  = mk(0, 0, 1, 'hA4, 0, 0, 1, 'hA0, 4);
    tbl[9]  = mk(0, 0, 1, 'hA4, 1, 0, 1, 'hA0, 4);
    tbl[10] = mk(0, 0, 1, 'hA4, 1, 0, 1, 'hA1, 3);
    tbl[11] = mk(0, 0, 1, 'hA4, 1, 1, 1, 'hA2, 2);
    tbl[12] = mk(0, 0, 1, 'hA5, 1, 1, 1, 'hA3, 2);
    tbl[13] = mk(0, 0, 0, 'h00, 1, 1, 1, 'hA4, 2);
    tbl[14] = mk(0, 0, 0, 'h00, 1, 1, 1, 'hA5, 1);
    tbl[15] = mk(0, 0, 0, 'h00, 1, 1, 0, 'h00, 0);

    for (int r = 0; r < 16; r++) begin
      drive(int'(tbl[r].rst), int'(tbl[r].flush), int'(tbl[r].iv), tbl[r].id,
            int'(tbl[r].ordy));
      check($sformatf("tbl%0d_in_ready", r), 64'(ir_a[1]), 64'(tbl[r].e_ir));
      check($sformatf("tbl%0d_out_valid", r), 64'(ov_a[1]), 64'(tbl[r].e_ov));
      check($sformatf("tbl%0d_occupancy", r), 64'(occ_a[1]), 64'(tbl[r].e_occ));
      if (tbl[r].e_ov) begin
        check($sformatf("tbl%0d_out_data", r), 64'(od_a[1]), 64'(tbl[r].e_od));
      end
    end

    // ---- Streaming 0x00..0x0F with out_ready high, all depths ----
    drive(1, 0, 0, 32'h0, 1);
    for (int c = 0; c < 22; c++) begin
      drive(0, 0, (c < 16) ? 1 : 0, 32'(c), 1);
      for (int d = 0; d < 3; d++) begin
        s = stages_of(d);
        acc_n = (c < 16) ? c : 16;
        del_n = (c - s < 0) ? 0 : ((c - s > 16) ? 16 : c - s);
        check($sformatf("stream_S%0d_c%0d_in_ready", s, c), 64'(ir_a[d]), 64'(1));
        check($sformatf("stream_S%0d_c%0d_out_valid", s, c), 64'(ov_a[d]),
              64'((c >= s) && (c < 16 + s)));
        check($sformatf("stream_S%0d_c%0d_occupancy", s, c), 64'(occ_a[d]),
              64'(acc_n - del_n));
        if ((c >= s) && (c < 16 + s)) begin
          check($sformatf("stream_S%0d_c%0d_out_data", s, c), 64'(od_a[d]), 64'(c - s));
        end
      end
    end

    // ---- Flush with three words held, STAGES=2 ----
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h11, 0);
    drive(0, 0, 1, 32'h22, 0);
    drive(0, 0, 1, 32'h33, 0);
    drive(0, 1, 1, 32'h44, 0);
    check("flush_cycle_in_ready", 64'(ir_a[1]), 64'(0));
    check("flush_cycle_occupancy", 64'(occ_a[1]), 64'(3));
    check("flush_cycle_out_data", 64'(od_a[1]), 64'(32'h11));
    drive(0, 0, 1, 32'h55, 1);
    check("post_flush_occupancy", 64'(occ_a[1]), 64'(0));
    check("post_flush_out_valid", 64'(ov_a[1]), 64'(0));
    check("post_flush_in_ready", 64'(ir_a[1]), 64'(1));
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 32'h0, 1);
      if (ov_a[1] && !seen) begin
        seen = 1'b1;
        check("post_flush_first_word", 64'(od_a[1]), 64'(32'h55));
      end
    end
    check("post_flush_word_seen", 64'(seen), 64'(1));

    // ---- Reset mid-stream with three words in flight ----
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h61, 0);
    drive(0, 0, 1, 32'h62, 0);
    drive(0, 0, 1, 32'h63, 0);
    drive(1, 0, 1, 32'h64, 0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("midrst_S%0d_in_ready", stages_of(d)), 64'(ir_a[d]), 64'(0));
    end
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 32'h0, 1);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("midrst_S%0d_c%0d_out_valid", stages_of(d), c),
              64'(ov_a[d]), 64'(0));
        check($sformatf("midrst_S%0d_c%0d_occupancy", stages_of(d), c),
              64'(occ_a[d]), 64'(0));
      end
    end

    // ---- Random valid/ready against a queue scoreboard, every depth ----
    for (int d = 0; d < 3; d++) begin
      s = stages_of(d);
      q.delete();
      sent = 0;
      got  = 0;
      cyc  = 0;
      drive(1, 0, 0, 32'h0, 0);
      while (got < 1000 && cyc < 20000) begin
        v_i = (sent < 1000) ? int'($urandom_range(0, 1)) : 0;
        o_i = int'($urandom_range(0, 1));
        d_i = $urandom;
        drive(0, 0, v_i, d_i, o_i);
        ir_snap = ir_a[d];
        check($sformatf("rand_S%0d_occupancy", s), 64'(occ_a[d]), 64'(q.size()));
        check($sformatf("rand_S%0d_valid_without_word", s),
              64'(ov_a[d] && (q.size() == 0)), 64'(0));
        // Flip out_ready inside the cycle; in_ready must not follow it.
        out_ready = (o_i == 0);
        #1;
        check($sformatf("rand_S%0d_in_ready_indep", s), 64'(ir_a[d]), 64'(ir_snap));
        out_ready = (o_i != 0);
        #1;
        if (ov_a[d] && (o_i != 0) && (q.size() > 0)) begin
          exp_word = q.pop_front();
          check($sformatf("rand_S%0d_word%0d", s, got), 64'(od_a[d]), 64'(exp_word));
          got++;
        end
        if ((v_i != 0) && ir_snap) begin
          q.push_back(d_i);
          sent++;
        end
        cyc++;
      end
      check($sformatf("rand_S%0d_words_delivered", s), 64'(got), 64'(1000));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/skid_pipeline.md
# skid_pipeline

Parametrised, fully registered valid/ready pipeline: a chain of `STAGES` skid-buffered register stages that sustains one transfer per cycle while registering every backward `ready` path. Successor to our single-entry pipeline register: it adds configurable depth, 2-entry-per-stage elasticity, synchronous flush and an occupancy output. It sits on long datapaths and between clock-region floorplan blocks where both the forward and backward timing paths must be cut.

## Interface
- `DATA_WIDTH`, 32: payload width in bits, ≥1.
- `STAGES`, 2: number of skid stages, ≥1; total capacity is `2*STAGES` words.
- `CNT_W`, `$clog2(2*STAGES+1)`: occupancy width (derived, not overridden).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous discard of all stored words.
- `in_data` in DATA_WIDTH: upstream payload.
- `in_valid` in 1: upstream word offered.
- `in_ready` out 1: stage-0 can accept; registered-state only, no combinational path from `out_ready`.
- `out_data` out DATA_WIDTH: last-stage main register.
- `out_valid` out 1: last-stage main register full.
- `out_ready` in 1: downstream accepts.
- `occupancy` out CNT_W: number of valid words held in all stages.

## Operation
- Each stage k holds `main` (valid+data) and `skid` (valid+data). Stage upstream-ready `up_rdy[k] = !skid_valid[k]`. Stage downstream-ready is `up_rdy[k+1]`, or `out_ready` for the last stage.
- Per stage, per cycle, with `acc` = (offered valid && `up_rdy[k]`) and `drn` = (`main_valid[k]` && downstream-ready):
  - `drn` and `skid_valid`: main ← skid; skid cleared. `acc` cannot occur because `up_rdy` is 0.
  - `drn`, no skid, `acc`: main ← incoming.
  - `drn`, no skid, no `acc`: main emptied.
  - No `drn`, `acc`, main empty: main ← incoming.
  - No `drn`, `acc`, main full: skid ← incoming.
  - Otherwise: hold.
- Order is strictly FIFO. No word is dropped or duplicated except by `flush`/`rst`.
- `in_ready = !skid_valid[0] && !flush && !rst`.
- `flush`: on the next edge all `main_valid`/`skid_valid` clear. A word offered in the flush cycle is not accepted. `out_valid` may still be 1 during the flush cycle and a transfer completed at that edge counts as delivered.
- `occupancy` = popcount of all main and skid valids. It is a registered-state function, updated on the edge.
- Data registers need no reset. Valid flags do.

## Timing
- During `rst` and on the first cycle after it: `out_valid=0`, `occupancy=0`. `in_ready=0` while `rst` is high and `1` on the first cycle after deassertion. `out_data` is don't-care while `out_valid=0`.
- Latency, empty pipe with `out_ready=1`: a word accepted at edge t is presented on `out_valid` after edge t+STAGES-1, i.e. it is visible `STAGES` cycles after it was offered. Transfer on `out` can occur in that cycle.
- Throughput is 1 word/cycle sustained with `out_ready` held high, with no bubbles.
- Backpressure: with `out_ready=0` from an empty state and `in_valid=1` continuously, exactly `2*STAGES` words are accepted. `in_ready` falls after the `2*STAGES`-th accept edge.
- After `out_ready` rises, `in_ready` at stage 0 rises no earlier than the following edges, since ready propagates one stage per cycle. The skid slots absorb the in-flight words.
- Simultaneous accept and drain on a full-main, empty-skid stage: the word passes through, occupancy is unchanged.
- `rst` mid-operation: all valids clear at that edge and contents are lost. Same as `flush`, plus `in_ready=0` for that cycle.

## Test plan
- Reset: hold `rst` for 3 cycles with `in_valid=1` -> no accept, `out_valid=0`, `occupancy=0`. `in_ready=1` on the first cycle after release.
- Streaming, STAGES=2, DATA_WIDTH=32: send 0x00..0x0F back-to-back with `out_ready=1` -> first output 2 cycles after first offer, then 16 consecutive outputs in order with no gaps, `occupancy` steady at 2.
- Full backpressure, STAGES=2: `out_ready=0`, stream 0xA0.. -> exactly 4 accepts (0xA0–0xA3), `in_ready=0`, `occupancy=4`. Then raise `out_ready` -> 0xA0–0xA3 then 0xA4.. delivered in order, none lost.
- Random stalls, STAGES=1 and STAGES=4: 1000 words, `in_valid`/`out_ready` 50% random -> scoreboard exact order match, `in_ready` never depends on same-cycle `out_ready`.
- Flush: fill 3 words (0x11, 0x22, 0x33) with `out_ready=0`, pulse `flush` while offering 0x44 -> 0x44 not accepted, `occupancy=0` and `out_valid=0` next cycle. Subsequent 0x55 emerges as the first output.
- Reset mid-stream: assert `rst` for 1 cycle with 3 words in flight -> all cleared, no stale word ever appears on `out_data` with `out_valid=1`.
